// File: rtl/ama_riscv_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ama_riscv_fetch
// Brief    : Instruction prefetch stage. Issues sequential imem requests under
//            a credit limit, buffers responses in order, drops stale
//            responses after an EXE redirect.
// Revision : 1.0 - initial release
// ============================================================================
module ama_riscv_fetch #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int          BUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        imem_rsp_ready,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int c_aw = $clog2(BUF_DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);
    localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);
    localparam logic [c_cw-1:0] c_full    = c_cw'(BUF_DEPTH);
    localparam logic [c_cw:0]   c_credits = (c_cw + 1)'(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [31:0]       r_fetch_pc;
    logic [31:0]       r_out_pc;
    logic [c_cw-1:0]   r_outstanding;
    logic [c_cw-1:0]   r_drop_cnt;
    logic [c_cw-1:0]   r_count;
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [31:0]       r_mem [BUF_DEPTH];

    logic [c_cw:0]     w_used;
    logic              w_req_fire;
    logic              w_rsp_fire;
    logic              w_drop;
    logic              w_push;
    logic              w_pop;
    logic [31:0]       w_target;
    logic [c_cw-1:0]   w_outstanding_next;
    logic [c_cw-1:0]   w_drop_next;
    logic              w_unused_pc_lsb;

    assign w_unused_pc_lsb = &{1'b0, redirect_pc[1:0]};
    assign w_target        = {redirect_pc[31:2], 2'b00};

    // Credits count requests in flight plus buffered entries, from registers only
    assign w_used     = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_req_fire = imem_req_valid && imem_req_ready;
    assign w_rsp_fire = imem_rsp_valid && imem_rsp_ready;
    assign w_drop     = w_rsp_fire && (r_drop_cnt != '0);
    assign w_push     = w_rsp_fire && (r_drop_cnt == '0) && !redirect_valid;
    assign w_pop      = inst_valid && inst_ready;

    assign imem_req_addr = r_fetch_pc;
    assign inst_valid    = (r_count != '0) && !redirect_valid;
    assign inst_data     = r_mem[r_rd_ptr];
    assign inst_pc       = r_out_pc;

    always_comb begin
        w_outstanding_next = r_outstanding;
        if (w_req_fire && !w_rsp_fire) begin
            w_outstanding_next = r_outstanding + c_cnt_one;
        end else if (!w_req_fire && w_rsp_fire) begin
            w_outstanding_next = r_outstanding - c_cnt_one;
        end
    end

    // No request is issued during a redirect, so everything still in flight
    // afterwards belongs to the old path and must be dropped.
    always_comb begin
        w_drop_next = r_drop_cnt;
        if (redirect_valid) begin
            w_drop_next = w_outstanding_next;
        end else if (w_drop) begin
            w_drop_next = r_drop_cnt - c_cnt_one;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        imem_req_valid = 1'b0;
        imem_rsp_ready = 1'b0;
        case (r_state)
            ST_RST: begin
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                imem_req_valid = !redirect_valid && (w_used < c_credits);
                imem_rsp_ready = 1'b1;
                if (redirect_valid && (w_drop_next != '0)) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                imem_req_valid = !redirect_valid && (w_used < c_credits);
                imem_rsp_ready = 1'b1;
                if (w_drop_next == '0) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_RST;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RST;
            r_fetch_pc    <= RESET_VEC;
            r_out_pc      <= RESET_VEC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            r_state       <= w_state_next;
            r_outstanding <= w_outstanding_next;
            r_drop_cnt    <= w_drop_next;
            if (redirect_valid) begin
                r_fetch_pc <= w_target;
                r_out_pc   <= w_target;
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_pop) begin
                    r_out_pc <= r_out_pc + 32'd4;
                    r_rd_ptr <= r_rd_ptr + c_ptr_one;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_one;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_cnt_one;
                    2'b01:   r_count <= r_count - c_cnt_one;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= imem_rsp_data;
        end
    end

    // Simulation-only protocol checks
    a_no_rsp_idle : assert property (@(posedge clk) disable iff (rst)
        w_rsp_fire |-> (r_outstanding != '0));
    a_no_push_full : assert property (@(posedge clk) disable iff (rst)
        w_push |-> (r_count != c_full));
    a_credit_bound : assert property (@(posedge clk) disable iff (rst)
        w_used <= c_credits);

endmodule
`default_nettype wire

// File: tb/tb_ama_riscv_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ama_riscv_fetch
// Brief    : Directed scoreboard bench for ama_riscv_fetch with a simple
//            in-order imem model (data = address, 1-cycle latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ama_riscv_fetch;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        imem_rsp_ready;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;

    ama_riscv_fetch #(
        .RESET_VEC (32'h0000_0100),
        .BUF_DEPTH (4)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_ready (imem_rsp_ready),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] pend[$];
    logic [31:0] junk;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        rsp_en = 1'b0;
    logic        req_fire_s = 1'b0;
    logic        rsp_fire_s = 1'b0;
    logic [31:0] addr_s = 32'h0;
    int          nreq_total = 0;
    int          nreq_base = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Handshakes as seen just before each rising edge
    always @(posedge clk) begin
        req_fire_s = imem_req_valid && imem_req_ready;
        rsp_fire_s = imem_rsp_valid && imem_rsp_ready;
        addr_s     = imem_req_addr;
        if (req_fire_s) nreq_total++;
    end

    // imem model: in-order, data equals address, reset with the DUT
    always @(negedge clk) begin
        #1;
        if (rst) begin
            pend.delete();
        end else begin
            if (rsp_fire_s && pend.size() > 0) junk = pend.pop_front();
            if (req_fire_s) pend.push_back(addr_s);
        end
        imem_rsp_valid = rsp_en && !rst && (pend.size() > 0);
        imem_rsp_data  = (pend.size() > 0) ? pend[0] : 32'h0;
    end

    // Scoreboard monitor: every decode handshake must match the queue head
    always @(posedge clk) begin
        if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_inst: got pc 0x%08h, expected no handshake", inst_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("inst_pc", inst_pc, mon_e.pc);
                check("inst_data", inst_data, mon_e.data);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pc   = base + 32'(4 * i);
            e.data = base + 32'(4 * i);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_empty(input string name, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            step();
            k++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: got %0d entries left, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        rsp_en         = 1'b0;
        repeat (3) step();
        rst       = 1'b0;
        nreq_base = nreq_total;
    endtask

    initial begin
        int k;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        rsp_en         = 1'b0;
        repeat (3) step();
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_rsp_ready", 32'(imem_rsp_ready), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst_pc", inst_pc, 32'h100);
        check("rst_req_addr", imem_req_addr, 32'h100);

        // Credit limit: one idle cycle, four requests, then nothing
        rst = 1'b0;
        #1;
        check("t1_idle_req_valid", 32'(imem_req_valid), 32'd0);
        for (int i = 0; i < 7; i++) begin
            step();
            if (i < 4) begin
                check("t1_req_valid", 32'(imem_req_valid), 32'd1);
                check("t1_req_addr", imem_req_addr, 32'h100 + 32'(4 * i));
            end else begin
                check("t1_req_stop", 32'(imem_req_valid), 32'd0);
            end
        end

        // Streaming without gaps
        do_reset();
        rsp_en     = 1'b1;
        inst_ready = 1'b1;
        push_seq(32'h100, 16);
        k = 0;
        while (!inst_valid && k < 20) begin
            step();
            k++;
        end
        while (exp_q.size() != 0 && k < 60) begin
            check("t2_no_gap", 32'(inst_valid), 32'd1);
            step();
            k++;
        end
        wait_empty("t2", 20);
        inst_ready = 1'b0;

        // Backpressure: buffer fills with 0x100..0x10C, requests stop
        do_reset();
        rsp_en = 1'b1;
        repeat (10) step();
        check("t3_full_valid", 32'(inst_valid), 32'd1);
        check("t3_head_pc", inst_pc, 32'h100);
        check("t3_head_data", inst_data, 32'h100);
        check("t3_req_stopped", 32'(imem_req_valid), 32'd0);
        push_seq(32'h100, 12);
        inst_ready = 1'b1;
        wait_empty("t3", 60);
        inst_ready = 1'b0;

        // Redirect with three requests in flight
        do_reset();
        inst_ready = 1'b1;
        k = 0;
        while ((nreq_total - nreq_base) < 3 && k < 20) begin
            step();
            k++;
        end
        imem_req_ready = 1'b0;
        step();
        push_seq(32'h200, 8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        imem_req_ready = 1'b1;
        #1;
        check("t4_redir_inst_valid", 32'(inst_valid), 32'd0);
        check("t4_redir_req_valid", 32'(imem_req_valid), 32'd0);
        step();
        redirect_valid = 1'b0;
        rsp_en         = 1'b1;
        #1;
        check("t4_new_req_valid", 32'(imem_req_valid), 32'd1);
        check("t4_new_req_addr", imem_req_addr, 32'h200);
        check("t4_inst_valid_empty", 32'(inst_valid), 32'd0);
        wait_empty("t4", 60);
        inst_ready = 1'b0;

        // Redirect, response arrival and inst_ready in the same cycle
        do_reset();
        rsp_en     = 1'b1;
        inst_ready = 1'b1;
        push_seq(32'h100, 8);
        wait_empty("t5_pre", 40);
        check("t5_pre_inst_valid", 32'(inst_valid), 32'd1);
        check("t5_pre_rsp_ready", 32'(imem_rsp_ready & imem_rsp_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        #1;
        check("t5_redir_inst_valid", 32'(inst_valid), 32'd0);
        check("t5_redir_req_valid", 32'(imem_req_valid), 32'd0);
        push_seq(32'h200, 6);
        step();
        redirect_valid = 1'b0;
        #1;
        check("t5_post_inst_valid", 32'(inst_valid), 32'd0);
        check("t5_post_req_valid", 32'(imem_req_valid), 32'd1);
        check("t5_post_req_addr", imem_req_addr, 32'h200);
        wait_empty("t5", 40);
        inst_ready = 1'b0;

        // Request stall, then reset mid-stream
        do_reset();
        rsp_en     = 1'b1;
        inst_ready = 1'b1;
        push_seq(32'h100, 8);
        k = 0;
        while ((nreq_total - nreq_base) < 1 && k < 20) begin
            step();
            k++;
        end
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t6_stall_valid", 32'(imem_req_valid), 32'd1);
            check("t6_stall_addr", imem_req_addr, 32'h104);
        end
        imem_req_ready = 1'b1;
        wait_empty("t6", 40);
        inst_ready = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        check("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("t6_rst_rsp_ready", 32'(imem_rsp_ready), 32'd0);
        check("t6_rst_inst_valid", 32'(inst_valid), 32'd0);
        check("t6_rst_inst_pc", inst_pc, 32'h100);
        rst = 1'b0;
        push_seq(32'h100, 4);
        inst_ready = 1'b1;
        k = 0;
        while (!imem_req_valid && k < 10) begin
            step();
            k++;
        end
        check("t6_restart_addr", imem_req_addr, 32'h100);
        wait_empty("t6_restart", 40);
        inst_ready = 1'b0;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
